// File: rtl/pattern_host_driver_pkg.sv
// ============================================================================
//  Module      : pattern_host_pkg
//  Description : Shared constants and FSM state type for the pattern matcher
//                host-side register driver.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package pattern_host_pkg;

    localparam int OUTCOME_W = 16;
    localparam int CPU_W     = 64;

    localparam logic [2:0] A_STR_HI = 3'd0;
    localparam logic [2:0] A_STR_LO = 3'd1;
    localparam logic [2:0] A_PAT    = 3'd2;
    localparam logic [2:0] A_WC     = 3'd3;
    localparam logic [2:0] A_RES    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_SH   = 3'd1,
        ST_WR_SL   = 3'd2,
        ST_WR_PAT  = 3'd3,
        ST_WR_WC   = 3'd4,
        ST_RD_REQ  = 3'd5,
        ST_RD_WAIT = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    // Matcher addresses are 3 bits wide; the bus carries them zero-extended.
    function automatic logic [CPU_W-1:0] bus_addr(input logic [2:0] a);
        return {{(CPU_W-3){1'b0}}, a};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_host_driver_if.sv
// ============================================================================
//  Module      : pattern_host_driver_if
//  Description : Job handshake, result handshake and matcher register bus.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface pattern_host_driver_if;
    import pattern_host_pkg::*;

    logic                 job_valid;
    logic                 job_ready;
    logic [127:0]         job_string;
    logic [63:0]          job_pattern;
    logic [7:0]           job_wildcard;

    logic                 res_valid;
    logic                 res_ready;
    logic [OUTCOME_W-1:0] res_outcome;
    logic                 res_hit;

    logic [CPU_W-1:0]     cpu_din;
    logic [CPU_W-1:0]     cpu_ain;
    logic                 cpu_wren;
    logic [CPU_W-1:0]     cpu_dout;

    logic                 busy;

    modport master (
        input  job_valid, job_string, job_pattern, job_wildcard,
        input  res_ready, cpu_dout,
        output job_ready, res_valid, res_outcome, res_hit,
        output cpu_din, cpu_ain, cpu_wren, busy
    );

    modport slave (
        output job_valid, job_string, job_pattern, job_wildcard,
        output res_ready, cpu_dout,
        input  job_ready, res_valid, res_outcome, res_hit,
        input  cpu_din, cpu_ain, cpu_wren, busy
    );

endinterface

`default_nettype wire

// File: rtl/pattern_host_driver.sv
// ============================================================================
//  Module      : pattern_host_driver
//  Description : Issues the matcher register write/read sequence for one job
//                and returns the outcome; skips unchanged pattern/wildcard.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pattern_host_driver
    import pattern_host_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pattern_host_driver_if.master bus
);

    localparam logic [1:0] C_RD_LAST = 2'(RD_LAT - 1);

    state_t               r_state;
    state_t               w_next;

    logic [127:0]         r_string;
    logic [63:0]          r_pattern;
    logic [7:0]           r_wildcard;
    logic [63:0]          r_cache_pat;
    logic [7:0]           r_cache_wc;
    logic                 r_cache_vld;
    logic [1:0]           r_rd_cnt;
    logic [OUTCOME_W-1:0] r_outcome;

    logic                 w_pat_diff;
    logic                 w_wc_diff;
    logic                 w_rd_last;
    logic [CPU_W-1:0]     w_din;
    logic [CPU_W-1:0]     w_ain;
    logic                 w_wren;
    logic                 w_unused_dout;

    assign w_pat_diff    = !r_cache_vld || (r_pattern  != r_cache_pat);
    assign w_wc_diff     = !r_cache_vld || (r_wildcard != r_cache_wc);
    assign w_rd_last     = (r_rd_cnt == C_RD_LAST);
    assign w_unused_dout = &{1'b0, bus.cpu_dout[CPU_W-1:OUTCOME_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Job copy is only loaded on acceptance, so it needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && bus.job_valid) begin
            r_string   <= bus.job_string;
            r_pattern  <= bus.job_pattern;
            r_wildcard <= bus.job_wildcard;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_vld <= 1'b0;
            r_cache_pat <= '0;
            r_cache_wc  <= '0;
            r_rd_cnt    <= '0;
            r_outcome   <= '0;
        end else begin
            if (r_state == ST_RD_REQ) begin
                r_rd_cnt <= '0;
            end else if (r_state == ST_RD_WAIT) begin
                r_rd_cnt <= r_rd_cnt + 2'd1;
            end
            if (r_state == ST_RD_WAIT && w_rd_last) begin
                r_outcome   <= bus.cpu_dout[OUTCOME_W-1:0];
                r_cache_pat <= r_pattern;
                r_cache_wc  <= r_wildcard;
                r_cache_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_din  = '0;
        w_ain  = '0;
        w_wren = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.job_valid) w_next = ST_WR_SH;
            end
            ST_WR_SH: begin
                w_wren = 1'b1;
                w_ain  = bus_addr(A_STR_HI);
                w_din  = r_string[127:64];
                w_next = ST_WR_SL;
            end
            ST_WR_SL: begin
                w_wren = 1'b1;
                w_ain  = bus_addr(A_STR_LO);
                w_din  = r_string[63:0];
                if (w_pat_diff)     w_next = ST_WR_PAT;
                else if (w_wc_diff) w_next = ST_WR_WC;
                else                w_next = ST_RD_REQ;
            end
            ST_WR_PAT: begin
                w_wren = 1'b1;
                w_ain  = bus_addr(A_PAT);
                w_din  = r_pattern;
                w_next = w_wc_diff ? ST_WR_WC : ST_RD_REQ;
            end
            ST_WR_WC: begin
                w_wren = 1'b1;
                w_ain  = bus_addr(A_WC);
                w_din  = {56'h0, r_wildcard};
                w_next = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                w_ain  = bus_addr(A_RES);
                w_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Address held so the registered read data stays valid.
                w_ain  = bus_addr(A_RES);
                if (w_rd_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.res_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.cpu_din     = w_din;
    assign bus.cpu_ain     = w_ain;
    assign bus.cpu_wren    = w_wren;
    assign bus.job_ready   = (r_state == ST_IDLE);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.res_valid   = (r_state == ST_DONE);
    assign bus.res_outcome = r_outcome;
    assign bus.res_hit     = |r_outcome;

endmodule

`default_nettype wire

// File: tb/tb_pattern_host_driver.sv
// ============================================================================
//  Module      : tb_pattern_host_driver
//  Description : Scoreboard bench for pattern_host_driver (RD_LAT 1 and 3)
//                with a behavioural matcher register block as responder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_host_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_host_driver_if bus1();
    pattern_host_driver_if bus3();

    pattern_host_driver #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
    pattern_host_driver #(.RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.master));

    logic         sel = 1'b0;
    logic         j_valid = 1'b0;
    logic         j_res_ready = 1'b0;
    logic [127:0] j_string = '0;
    logic [63:0]  j_pattern = '0;
    logic [7:0]   j_wildcard = '0;

    assign bus1.job_valid    = j_valid && !sel;
    assign bus3.job_valid    = j_valid && sel;
    assign bus1.res_ready    = j_res_ready && !sel;
    assign bus3.res_ready    = j_res_ready && sel;
    assign bus1.job_string   = j_string;
    assign bus3.job_string   = j_string;
    assign bus1.job_pattern  = j_pattern;
    assign bus3.job_pattern  = j_pattern;
    assign bus1.job_wildcard = j_wildcard;
    assign bus3.job_wildcard = j_wildcard;

    logic        m_job_ready, m_res_valid, m_res_hit, m_wren, m_busy;
    logic [15:0] m_outcome;
    logic [63:0] m_din, m_ain;
    assign m_job_ready = sel ? bus3.job_ready   : bus1.job_ready;
    assign m_res_valid = sel ? bus3.res_valid   : bus1.res_valid;
    assign m_res_hit   = sel ? bus3.res_hit     : bus1.res_hit;
    assign m_outcome   = sel ? bus3.res_outcome : bus1.res_outcome;
    assign m_wren      = sel ? bus3.cpu_wren    : bus1.cpu_wren;
    assign m_din       = sel ? bus3.cpu_din     : bus1.cpu_din;
    assign m_ain       = sel ? bus3.cpu_ain     : bus1.cpu_ain;
    assign m_busy      = sel ? bus3.busy        : bus1.busy;

    // Outcome bit i: pattern byte j matches string byte (i+j) mod 16 for all
    // non-wildcarded j.
    function automatic logic [15:0] match_fn(input logic [127:0] s, input logic [63:0] p,
                                             input logic [7:0] w);
        logic [15:0] r;
        logic        ok;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            ok = 1'b1;
            for (int j = 0; j < 8; j++)
                if (!w[j] && s[8*((i+j)%16) +: 8] != p[8*j +: 8]) ok = 1'b0;
            r[i] = ok;
        end
        return r;
    endfunction

    logic [63:0] m1_regs [4];
    logic [63:0] m3_regs [4];
    always @(posedge clk) begin
        if (bus1.cpu_wren) m1_regs[bus1.cpu_ain[1:0]] <= bus1.cpu_din;
        bus1.cpu_dout <= (!bus1.cpu_wren && bus1.cpu_ain[2])
            ? {48'h0, match_fn({m1_regs[0], m1_regs[1]}, m1_regs[2], m1_regs[3][7:0])}
            : 64'hDEAD_BEEF_0BAD_F00D;
    end
    always @(posedge clk) begin
        if (bus3.cpu_wren) m3_regs[bus3.cpu_ain[1:0]] <= bus3.cpu_din;
        bus3.cpu_dout <= (!bus3.cpu_wren && bus3.cpu_ain[2])
            ? {48'h0, match_fn({m3_regs[0], m3_regs[1]}, m3_regs[2], m3_regs[3][7:0])}
            : 64'hDEAD_BEEF_0BAD_F00D;
    end

    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] sb [$];
    int          full_rc1 = 0;

    localparam logic [127:0] S_A  = 128'h41424344_45464748_41424344_45464748;
    localparam logic [127:0] S_B  = 128'h48474645_44434241_41424344_31323334;
    localparam logic [127:0] S_C  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] S_D  = 128'h41424344_41424344_DEADBEEF_41424344;
    localparam logic [63:0]  P_A  = 64'h41424344_00000000;
    localparam logic [63:0]  P_B  = 64'h33221100_77665544;
    localparam logic [63:0]  P_C  = 64'h0BAD0BAD_CAFEF00D;

    task automatic do_job(input logic [127:0] s, input logic [63:0] p, input logic [7:0] w,
                          input logic [3:0] exp_mask, input int hold, input bit keep_valid,
                          input string nm, output int res_cyc);
        logic [3:0]  seen;
        logic [1:0]  a;
        logic [63:0] exp_din;
        logic [15:0] exp_out, got;
        int          rd_cyc, exp_res;
        seen    = '0;
        rd_cyc  = -1;
        res_cyc = -1;
        exp_res = $countones(exp_mask) + 2 + (sel ? 3 : 1);
        n_total++;
        if (m_job_ready !== 1'b1) $display("FAIL %s ready_idle: got %b want 1", nm, m_job_ready);
        else n_pass++;
        j_string = s; j_pattern = p; j_wildcard = w; j_valid = 1'b1;
        sb.push_back(match_fn(s, p, w));
        @(negedge clk);
        j_valid = keep_valid;
        j_string = ~s; j_pattern = ~p; j_wildcard = ~w;
        n_total++;
        if (m_job_ready !== 1'b0) $display("FAIL %s ready_busy: got %b want 0", nm, m_job_ready);
        else n_pass++;
        for (int k = 1; k <= 20; k++) begin
            if (m_wren) begin
                a = m_ain[1:0];
                case (a)
                    2'd0: exp_din = s[127:64];
                    2'd1: exp_din = s[63:0];
                    2'd2: exp_din = p;
                    default: exp_din = {56'h0, w};
                endcase
                n_total++;
                if (m_ain >= 64'd4 || k != 1 + $countones(seen) || (4'(seen >> a)) != 4'd0)
                    $display("FAIL %s wr_order: addr %0d at cycle %0d, prior mask %b", nm, m_ain, k, seen);
                else n_pass++;
                n_total++;
                if (m_din !== exp_din) $display("FAIL %s wr_data: addr %0d got %h want %h", nm, a, m_din, exp_din);
                else n_pass++;
                seen[a] = 1'b1;
            end else if (m_ain == 64'd4 && rd_cyc < 0) begin
                rd_cyc = k;
            end
            if (m_res_valid) begin
                res_cyc = k;
                break;
            end
            @(negedge clk);
        end
        n_total++;
        if (seen !== exp_mask) $display("FAIL %s wr_set: got %b want %b", nm, seen, exp_mask);
        else n_pass++;
        n_total++;
        if (rd_cyc != $countones(exp_mask) + 1)
            $display("FAIL %s rd_cycle: got %0d want %0d", nm, rd_cyc, $countones(exp_mask) + 1);
        else n_pass++;
        n_total++;
        if (res_cyc != exp_res) $display("FAIL %s res_cycle: got %0d want %0d", nm, res_cyc, exp_res);
        else n_pass++;
        exp_out = sb.pop_front();
        if (res_cyc < 0) return;
        got = m_outcome;
        n_total++;
        if (got !== exp_out) $display("FAIL %s outcome: got %h want %h", nm, got, exp_out);
        else n_pass++;
        n_total++;
        if (m_res_hit !== (|exp_out)) $display("FAIL %s hit: got %b want %b", nm, m_res_hit, |exp_out);
        else n_pass++;
        n_total++;
        if ({m_wren, m_ain, m_din, m_job_ready, m_busy} !== {1'b0, 64'h0, 64'h0, 1'b0, 1'b1})
            $display("FAIL %s done_bus: wren %b ain %h din %h ready %b busy %b",
                     nm, m_wren, m_ain, m_din, m_job_ready, m_busy);
        else n_pass++;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_total++;
            if ({m_res_valid, m_outcome, m_job_ready, m_wren, m_ain} !== {1'b1, got, 1'b0, 1'b0, 64'h0})
                $display("FAIL %s hold%0d: valid %b out %h ready %b wren %b ain %h",
                         nm, h, m_res_valid, m_outcome, m_job_ready, m_wren, m_ain);
            else n_pass++;
        end
        j_res_ready = 1'b1;
        @(negedge clk);
        j_res_ready = 1'b0;
        n_total++;
        if ({m_job_ready, m_res_valid, m_busy} !== 3'b100)
            $display("FAIL %s release: ready/valid/busy got %b want 100",
                     nm, {m_job_ready, m_res_valid, m_busy});
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus1.job_ready, bus1.res_valid, bus1.res_outcome, bus1.res_hit, bus1.busy}
            !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL reset_status: ready %b valid %b out %h hit %b busy %b", bus1.job_ready,
                     bus1.res_valid, bus1.res_outcome, bus1.res_hit, bus1.busy);
        else n_pass++;
        n_total++;
        if ({bus1.cpu_din, bus1.cpu_ain, bus1.cpu_wren} !== {64'h0, 64'h0, 1'b0})
            $display("FAIL reset_bus: din %h ain %h wren %b", bus1.cpu_din, bus1.cpu_ain, bus1.cpu_wren);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({bus1.job_ready, bus1.busy} !== 2'b10)
            $display("FAIL reset_release: ready/busy got %b want 10", {bus1.job_ready, bus1.busy});
        else n_pass++;
    endtask

    task automatic test_full_job;
        do_job(S_A, P_A, 8'h0F, 4'b1111, 0, 1'b0, "full", full_rc1);
    endtask

    task automatic test_cached;
        int rc;
        do_job(S_B, P_A, 8'h0F, 4'b0011, 0, 1'b0, "cached", rc);
    endtask

    task automatic test_wc_change;
        int rc;
        do_job(S_B, P_A, 8'h00, 4'b1011, 0, 1'b0, "wc_change", rc);
    endtask

    task automatic test_back_to_back;
        int rc;
        do_job(S_C, P_B, 8'h55, 4'b1111, 10, 1'b1, "hold", rc);
        do_job(S_D, P_B, 8'h55, 4'b0011, 0, 1'b0, "next", rc);
    endtask

    task automatic test_reset_mid;
        int rc;
        j_string = S_A; j_pattern = P_C; j_wildcard = 8'h55; j_valid = 1'b1;
        @(negedge clk);
        j_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({m_wren, m_ain} !== {1'b1, 64'd2})
            $display("FAIL rstmid_wr_pat: wren %b ain %h want 1/2", m_wren, m_ain);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({m_wren, m_busy, m_job_ready} !== 3'b001)
            $display("FAIL rstmid_abort: wren/busy/ready got %b want 001", {m_wren, m_busy, m_job_ready});
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_total++;
            if ({m_res_valid, m_wren} !== 2'b00)
                $display("FAIL rstmid_quiet%0d: valid/wren got %b want 00", i, {m_res_valid, m_wren});
            else n_pass++;
        end
        do_job(S_A, P_C, 8'h55, 4'b1111, 0, 1'b0, "after_rst", rc);
    endtask

    task automatic test_rd_lat;
        int rc;
        sel = 1'b1;
        @(negedge clk);
        do_job(S_A, P_A, 8'h0F, 4'b1111, 0, 1'b0, "lat3_full", rc);
        n_total++;
        if (rc - full_rc1 != 2) $display("FAIL lat3_delta: got %0d want 2", rc - full_rc1);
        else n_pass++;
        do_job(S_D, P_A, 8'h0F, 4'b0011, 0, 1'b0, "lat3_cached", rc);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_cached();
        test_wc_change();
        test_back_to_back();
        test_reset_mid();
        test_rd_lat();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
